// File: rtl/key_click_decoder_pkg.sv
// Shared definitions for the key path: state encodings and default timing constants.
// The key filter, click decoder and LED/mode stages all import this package.
package key_click_decoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // 300 ms gesture window at 50 MHz, expressed as length minus one
    localparam int unsigned CNT_W_DEF      = 24;
    localparam logic [23:0] CNT_WIN_DEF    = 24'd14_999_999;
    localparam int unsigned MAX_CLICKS_DEF = 3;
    localparam int unsigned NUM_W_DEF      = 2;

endpackage

// File: rtl/key_win_timer.sv
// Window counter with clear and enable; done is registered and high while win_cnt==CNT_WIN.
// Also suitable as a long-press timer.
module key_win_timer #(
    parameter int unsigned        CNT_W   = 24,
    parameter logic [CNT_W-1:0]   CNT_WIN = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Saturates at CNT_WIN so the count can never wrap
    always_comb begin
        cnt_nxt = win_cnt;
        if (clr)
            cnt_nxt = '0;
        else if (en && win_cnt != CNT_WIN)
            cnt_nxt = win_cnt + 1'b1;
    end

    // done is compared against the next value so it lines up with win_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            done    <= 1'b0;
        end else begin
            win_cnt <= cnt_nxt;
            done    <= (cnt_nxt == CNT_WIN);
        end
    end

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced press pulses into single/double/triple click gestures.
// Emits a one-cycle click_valid with the press count held on click_num.
module key_click_decoder
    import key_click_decoder_pkg::*;
#(
    parameter int unsigned        CNT_W      = CNT_W_DEF,
    parameter logic [CNT_W-1:0]   CNT_WIN    = CNT_W'(CNT_WIN_DEF),
    parameter int unsigned        MAX_CLICKS = MAX_CLICKS_DEF,
    parameter int unsigned        NUM_W      = NUM_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             key_flag,
    output logic             click_valid,
    output logic [NUM_W-1:0] click_num,
    output logic             busy
);

    state_e           state, state_nxt;
    logic [NUM_W-1:0] click_cnt, cnt_nxt;
    logic [NUM_W-1:0] num_nxt;
    logic             valid_nxt;
    logic             win_clr, win_en, win_done;

    key_win_timer #(
        .CNT_W   (CNT_W),
        .CNT_WIN (CNT_WIN)
    ) u_win (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .clr  (win_clr),
        .en   (win_en),
        .done (win_done)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            click_cnt   <= '0;
            click_valid <= 1'b0;
            click_num   <= '0;
        end else begin
            state       <= state_nxt;
            click_cnt   <= cnt_nxt;
            click_valid <= valid_nxt;
            click_num   <= num_nxt;
        end
    end

    // A press always restarts the window, so it beats a coincident timeout
    always_comb begin
        state_nxt = state;
        cnt_nxt   = click_cnt;
        valid_nxt = 1'b0;
        num_nxt   = click_num;
        win_clr   = 1'b1;
        win_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (key_flag) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = NUM_W'(1);
                end
            end
            ST_WAIT: begin
                if (key_flag) begin
                    if (int'(click_cnt) + 1 == int'(MAX_CLICKS)) begin
                        valid_nxt = 1'b1;
                        num_nxt   = NUM_W'(MAX_CLICKS);
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = click_cnt + 1'b1;
                    end
                end else if (win_done) begin
                    valid_nxt = 1'b1;
                    num_nxt   = click_cnt;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    win_clr = 1'b0;
                    win_en  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_WAIT);

endmodule
